// File: rtl/uart_pkg.sv
// Shared UART definitions: TX/RX FSM state encoding and framing constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with occupancy count; pointers wrap modulo DEPTH.
// Latency: a pushed entry is visible on pop_data/empty the cycle after the push edge.
// Backpressure: push is ignored while full, pop is ignored while empty (full/empty are registered-state based).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign pop_data = mem[rd_ptr];
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;

    // Storage array: written only on an accepted push, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves the level unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a byte FIFO; optional parity bit under UART_TX_PARITY_EN.
// Latency: a byte pushed into an empty FIFO with the line idle and tx_en=1 starts its start bit one edge later.
// Backpressure: wready drops when the FIFO is full; frames continue back-to-back while tx_en=1 and data is queued.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DIV_W = 16
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [DIV_W-1:0]       baud_div,
    input  logic                   tx_en,
`ifdef UART_TX_PARITY_EN
    input  logic                   parity_odd,
`endif
    input  logic [7:0]             wdata,
    input  logic                   wvalid,
    output logic                   wready,
    output logic                   UART_TX,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   fifo_empty
);

    localparam int         BIT_W    = $clog2(UART_DATA_BITS);
    localparam logic [2:0] BIT_LAST = BIT_W'(UART_DATA_BITS - 1);

    uart_state_t                 state_q, state_d;
    logic [DIV_W-1:0]            cnt_q, cnt_d;
    logic [BIT_W-1:0]            bit_q, bit_d;
    logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
    logic [UART_DATA_BITS-1:0]   fifo_rd_data;
    logic [DIV_W-1:0]            div_eff;
    logic                        fifo_full;
    logic                        bit_end;
    logic                        load;
    logic                        pop;
`ifdef UART_TX_PARITY_EN
    logic                        par_q, par_d;
`endif

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (HCLK),
        .rst       (HRESET),
        .push      (wvalid),
        .push_data (wdata),
        .pop       (pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign wready  = !fifo_full;
    assign busy    = (state_q != IDLE);
    // A divisor of 0 would stall the bit counter, so it is clamped to 1.
    assign div_eff = (baud_div == '0) ? DIV_W'(1) : baud_div;
    // cnt_q is always >= 1 while busy; <= keeps a corrupted 0 from stalling forever.
    assign bit_end = (cnt_q <= DIV_W'(1));

    // Next-state logic: bit timing, LSB-first shifting and FIFO pop at frame start.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        load    = 1'b0;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        // Reload at every bit boundary so a baud_div change lands on the next bit.
        if (state_q != IDLE) begin
            cnt_d = bit_end ? div_eff : (cnt_q - DIV_W'(1));
        end
        case (state_q)
            IDLE: begin
                if (tx_en && !fifo_empty) begin
                    load = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                // Chain straight into the next start bit when more data is waiting.
                if (bit_end) begin
                    if (tx_en && !fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            pop     = 1'b1;
            shift_d = fifo_rd_data;
            cnt_d   = div_eff;
            state_d = START;
`ifdef UART_TX_PARITY_EN
            // Parity is fixed at pop since the data bits are shifted out later.
            par_d   = (^fifo_rd_data) ^ parity_odd;
`endif
        end
    end

    // FSM, baud counter and shift register; reset aborts any frame in flight.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Line level decoded from the registered state.
    always_comb begin
        UART_TX = UART_IDLE_LEVEL;
        case (state_q)
            START:   UART_TX = 1'b0;
            DATA:    UART_TX = shift_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  UART_TX = par_q;
`endif
            default: UART_TX = UART_IDLE_LEVEL;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-level reference model, per-cycle compare, serial terminal.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_fifo;

    localparam int DEPTH = 8;
    localparam int DIV_W = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic             HCLK;
    logic             HRESET;
    logic [DIV_W-1:0] baud_div;
    logic             tx_en;
    logic             parity_odd;
    logic [7:0]       wdata;
    logic             wvalid;
    logic             wready;
    logic             UART_TX;
    logic             busy;
    logic [3:0]       fifo_level;
    logic             fifo_empty;

    int n_chk  = 0;
    int n_fail = 0;
    logic chk_en;
    logic term_en;

    logic [7:0] rx_q[$];
    logic       rx_par_q[$];
    logic [7:0] tbl [9] = '{8'h31, 8'hA5, 8'h00, 8'hFF, 8'h5A, 8'h81, 8'h7E, 8'h42, 8'hEE};

    // Reference model state: queued bytes and the frame currently on the wire.
    logic [7:0] m_q[$];
    logic       m_active;
    logic       m_bits [0:11];
    int         m_k;
    int         m_rem;

    uart_tx_fifo #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .baud_div   (baud_div),
        .tx_en      (tx_en),
`ifdef UART_TX_PARITY_EN
        .parity_odd (parity_odd),
`endif
        .wdata      (wdata),
        .wvalid     (wvalid),
        .wready     (wready),
        .UART_TX    (UART_TX),
        .busy       (busy),
        .fifo_level (fifo_level),
        .fifo_empty (fifo_empty)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: at each edge, advance the frame timeline, start a frame, accept a write.
    always @(posedge HCLK) begin
        int         sz;
        logic       start;
        logic [7:0] b;
        sz    = m_q.size();
        start = 1'b0;
        if (HRESET) begin
            m_q.delete();
            m_active = 1'b0;
        end else begin
            if (m_active) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_k++;
                    if (m_k == FB) begin
                        m_active = 1'b0;
                        if (tx_en && sz > 0) start = 1'b1;
                    end else begin
                        m_rem = eff(int'(baud_div));
                    end
                end
            end else if (tx_en && sz > 0) begin
                start = 1'b1;
            end
            if (start) begin
                b = m_q.pop_front();
                m_bits[0] = 1'b0;
                for (int i = 0; i < 8; i++) m_bits[1+i] = b[i];
`ifdef UART_TX_PARITY_EN
                m_bits[9] = (^b) ^ parity_odd;
`endif
                m_bits[FB-1] = 1'b1;
                m_k      = 0;
                m_rem    = eff(int'(baud_div));
                m_active = 1'b1;
            end
            if (wvalid && sz < DEPTH) m_q.push_back(wdata);
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge HCLK) begin
        if (chk_en) begin
            check("line",   UART_TX,    m_active ? m_bits[m_k] : 1'b1);
            check("busy",   busy,       m_active);
            check("level",  fifo_level, m_q.size());
            check("wready", wready,     m_q.size() < DEPTH);
            check("empty",  fifo_empty, m_q.size() == 0);
        end
    end

    // Serial terminal: mid-bit sampling at the current baud_div.
    always begin
        @(negedge HCLK);
        if (term_en && !HRESET && UART_TX === 1'b0) begin
            int d;
            logic [7:0] b;
            d = eff(int'(baud_div));
            repeat (d / 2) @(negedge HCLK);
            for (int i = 0; i < 8; i++) begin
                repeat (d) @(negedge HCLK);
                b[i] = UART_TX;
            end
`ifdef UART_TX_PARITY_EN
            repeat (d) @(negedge HCLK);
            rx_par_q.push_back(UART_TX);
`endif
            repeat (d) @(negedge HCLK);
            if (UART_TX === 1'b1) rx_q.push_back(b);
        end
    end

    task automatic sync();
        @(posedge HCLK);
        #2;
    endtask

    task automatic push(input logic [7:0] b);
        wdata  = b;
        wvalid = 1'b1;
        sync();
        wvalid = 1'b0;
    endtask

    // Counts busy cycles from now until busy falls; optionally changes baud mid-frame.
    task automatic measure(output int cyc, input int chg_at, input int new_div);
        int cnt;
        bit seen;
        cnt  = 0;
        seen = 0;
        cyc  = -1;
        for (int i = 0; i < 20000; i++) begin
            if (busy) begin
                cnt++;
                seen = 1;
                if (cnt == chg_at) baud_div = DIV_W'(new_div);
            end else if (seen) begin
                cyc = cnt;
                break;
            end
            sync();
        end
    endtask

    task automatic wait_drain(input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (!busy && fifo_empty) begin
                ok = 1;
                break;
            end
            sync();
        end
        check("drain_timeout", ok, 1);
    endtask

    function automatic logic [31:0] rx_at(input int i);
        return (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hFFFF;
    endfunction

    initial begin
        int cyc;
        HRESET = 1'b1; wvalid = 1'b0; wdata = 8'h00; tx_en = 1'b1;
        baud_div = 16'd10; parity_odd = 1'b0; term_en = 1'b0; chk_en = 1'b0;

        // Reset held for three edges.
        sync();
        chk_en = 1'b1;
        sync();
        sync();
        HRESET = 1'b0;
        sync();
        check("rst_line",   UART_TX,    1);
        check("rst_busy",   busy,       0);
        check("rst_level",  fifo_level, 0);
        check("rst_wready", wready,     1);
        check("rst_empty",  fifo_empty, 1);

        // Single frame 'U' at baud_div=10.
        rx_q.delete();
        term_en = 1'b1;
        push(8'h55);
        check("lat_pre", UART_TX, 1);
        sync();
        check("lat_start", UART_TX, 0);
        measure(cyc, -1, 0);
`ifdef UART_TX_PARITY_EN
        check("single_cycles", cyc, 110);
`else
        check("single_cycles", cyc, 100);
`endif
        repeat (3) sync();
        check("single_rx_n", rx_q.size(), 1);
        check("single_rx",   rx_at(0), 8'h55);

        // Back-to-back "Hi".
        rx_q.delete();
        check("b2b_lvl0", fifo_level, 0);
        wdata = 8'h48; wvalid = 1'b1;
        sync();
        check("b2b_lvl1", fifo_level, 1);
        wdata = 8'h69;
        sync();
        wvalid = 1'b0;
        check("b2b_lvl2", fifo_level, 1);
        measure(cyc, -1, 0);
`ifdef UART_TX_PARITY_EN
        check("b2b_cycles", cyc, 220);
`else
        check("b2b_cycles", cyc, 200);
`endif
        check("b2b_lvl3", fifo_level, 0);
        repeat (3) sync();
        check("b2b_rx_n", rx_q.size(), 2);
        check("b2b_rx0",  rx_at(0), 8'h48);
        check("b2b_rx1",  rx_at(1), 8'h69);
        term_en = 1'b0;

        // Full FIFO with the transmitter held off.
        baud_div = 16'd4;
        tx_en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wdata  = tbl[i];
            wvalid = 1'b1;
            sync();
        end
        wvalid = 1'b0;
        check("full_level",  fifo_level, 8);
        check("full_wready", wready,     0);
        rx_q.delete();
        term_en = 1'b1;
        tx_en = 1'b1;
        wait_drain(2000);
        repeat (4) sync();
        check("full_rx_n", rx_q.size(), 8);
        for (int i = 0; i < 8; i++) check("full_rx", rx_at(i), tbl[i]);
        term_en = 1'b0;

        // baud_div=0 behaves as 1.
        baud_div = 16'd0;
        rx_q.delete();
        term_en = 1'b1;
        push(8'hC3);
        measure(cyc, -1, 0);
`ifdef UART_TX_PARITY_EN
        check("div0_cycles", cyc, 11);
`else
        check("div0_cycles", cyc, 10);
`endif
        repeat (3) sync();
        check("div0_rx", rx_at(0), 8'hC3);
        term_en = 1'b0;

        // baud_div 10 -> 20 in the middle of data bit 3.
        baud_div = 16'd10;
        push(8'h0F);
        measure(cyc, 45, 20);
`ifdef UART_TX_PARITY_EN
        check("baudchg_cycles", cyc, 170);
`else
        check("baudchg_cycles", cyc, 150);
`endif

        // Reset in the middle of DATA with bytes still queued.
        baud_div = 16'd10;
        wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wdata = tbl[i];
            sync();
        end
        wvalid = 1'b0;
        repeat (30) sync();
        HRESET = 1'b1;
        sync();
        check("midrst_line",  UART_TX,    1);
        check("midrst_level", fifo_level, 0);
        check("midrst_busy",  busy,       0);
        HRESET = 1'b0;
        sync();

`ifdef UART_TX_PARITY_EN
        // Even parity of 0x07 is 1.
        rx_q.delete();
        rx_par_q.delete();
        term_en = 1'b1;
        parity_odd = 1'b0;
        push(8'h07);
        measure(cyc, -1, 0);
        check("par_cycles", cyc, 110);
        repeat (3) sync();
        check("par_rx",  rx_at(0), 8'h07);
        check("par_bit", (rx_par_q.size() > 0) ? {31'd0, rx_par_q[0]} : 32'hFFFF, 1);
        term_en = 1'b0;
`endif

        // Randomized traffic: writes, tx_en toggles, baud changes, rare resets.
        baud_div = 16'd2;
        for (int it = 0; it < 2500; it++) begin
            wvalid = ($urandom_range(0, 2) != 0);
            wdata  = 8'($urandom);
            if ($urandom_range(0, 39) == 0) tx_en = ~tx_en;
            if ($urandom_range(0, 149) == 0) baud_div = DIV_W'($urandom_range(0, 5));
            parity_odd = 1'($urandom);
            HRESET = ($urandom_range(0, 599) == 0);
            sync();
        end
        wvalid = 1'b0;
        HRESET = 1'b0;
        tx_en  = 1'b1;
        wait_drain(3000);
        sync();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
